// File: rtl/adl_pkg.sv
// Shared types and defaults for the registered address-decode / slave-select unit.
package adl_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } adl_state_e;

  localparam int unsigned ADL_ADDR_W     = 32;
  localparam int unsigned ADL_NUM_SLAVES = 4;
  localparam int unsigned ADL_SEL_BITS   = 2;
  localparam int unsigned ADL_TIMEOUT    = 16;

  // Widest select vector the helper can build; callers size-cast down to NUM_SLAVES.
  localparam int unsigned ADL_MAX_SLAVES = 256;

  function automatic logic [ADL_MAX_SLAVES-1:0] onehot(input int unsigned idx);
    return ADL_MAX_SLAVES'(1) << idx;
  endfunction

endpackage

// File: rtl/adl_wdt_counter.sv
// Saturating watchdog counter; expire flags the last permitted cycle of a transaction.
module adl_wdt_counter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] LAST_CNT = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] MAX_CNT  = '1;

  logic [TW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_count <= '0;
    end else if (en && (r_count != MAX_CNT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expire = (r_count == LAST_CNT);

endmodule

// File: rtl/adl_txn_decoder.sv
// Registered address decoder: latches a one-hot slave select per transaction and
// reports completion, unmapped-address and watchdog errors as done/err pulses.
module adl_txn_decoder
  import adl_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADL_ADDR_W,
  parameter int unsigned NUM_SLAVES = ADL_NUM_SLAVES,
  parameter int unsigned SEL_BITS   = ADL_SEL_BITS,
  parameter int unsigned TIMEOUT    = ADL_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [ADDR_W-1:0]     address,
  input  logic [NUM_SLAVES-1:0] slave_ack,
  output logic [NUM_SLAVES-1:0] slave_en,
  output logic [SEL_BITS-1:0]   sel_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  adl_state_e            r_state;
  logic [NUM_SLAVES-1:0] r_slave_en;
  logic [SEL_BITS-1:0]   r_sel_idx;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  logic [SEL_BITS-1:0]   w_idx;
  logic                  w_mapped;
  logic                  w_start;
  logic                  w_ack;
  logic                  w_expire;
  logic [NUM_SLAVES-1:0] w_sel_vec;

  assign w_idx     = address[ADDR_W-1 -: SEL_BITS];
  assign w_mapped  = (32'(w_idx) < NUM_SLAVES);
  assign w_start   = (r_state == IDLE) && req && w_mapped;
  assign w_sel_vec = NUM_SLAVES'(onehot(32'(w_idx)));
  // Only the latched slave's ack counts; masking with the held select ignores the rest.
  assign w_ack     = |(slave_ack & r_slave_en);

  generate
    if (SEL_BITS < ADDR_W) begin : g_addr_low
      logic w_addr_unused;
      assign w_addr_unused = ^address[ADDR_W-SEL_BITS-1:0];
    end
  endgenerate

  adl_wdt_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .clk    (clk),
    .reset  (reset),
    .clr    (w_start),
    .en     (r_state == ACTIVE),
    .expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_slave_en <= '0;
      r_sel_idx  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req) begin
            if (w_mapped) begin
              r_slave_en <= w_sel_vec;
              r_sel_idx  <= w_idx;
              r_busy     <= 1'b1;
              r_state    <= ACTIVE;
            end else begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          // Ack is checked first so a same-cycle ack beats the watchdog.
          if (w_ack || w_expire) begin
            r_slave_en <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_err      <= !w_ack;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign slave_en = r_slave_en;
  assign sel_idx  = r_sel_idx;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_adl_txn_decoder.sv
// Randomised and directed bench for adl_txn_decoder: a 4-slave and a 3-slave
// instance run in lockstep against a transaction-level reference model.
module tb_adl_txn_decoder;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [31:0] address;
  logic [3:0]  ack4;
  logic [2:0]  ack3;

  logic [3:0]  en4;
  logic [1:0]  sel4;
  logic        busy4, done4, err4;
  logic [2:0]  en3;
  logic [1:0]  sel3;
  logic        busy3, done3, err3;

  int n_checks = 0;
  int n_fail   = 0;

  int m_en[2], m_sel[2], m_busy[2], m_done[2], m_err[2], m_active[2], m_age[2];
  int nslv[2] = '{4, 3};

  always #5 clk = ~clk;

  adl_txn_decoder dut (
    .clk(clk), .reset(reset), .req(req), .address(address), .slave_ack(ack4),
    .slave_en(en4), .sel_idx(sel4), .busy(busy4), .done(done4), .err(err4)
  );

  adl_txn_decoder #(.NUM_SLAVES(3)) dut3 (
    .clk(clk), .reset(reset), .req(req), .address(address), .slave_ack(ack3),
    .slave_en(en3), .sel_idx(sel3), .busy(busy3), .done(done3), .err(err3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level view: a transaction is either open (with its age in cycles) or not.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int ack;
      int idx;
      ack = (i == 0) ? int'(ack4) : int'(ack3);
      if (reset) begin
        m_en[i] = 0; m_sel[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_err[i] = 0;
        m_active[i] = 0; m_age[i] = 0;
      end else begin
        m_done[i] = 0;
        m_err[i]  = 0;
        if (m_active[i] == 0) begin
          if (req) begin
            idx = int'(address / 32'h4000_0000);
            if (idx < nslv[i]) begin
              m_active[i] = 1; m_age[i] = 0;
              m_en[i] = 2 ** idx; m_sel[i] = idx; m_busy[i] = 1;
            end else begin
              m_done[i] = 1; m_err[i] = 1;
            end
          end
        end else if (((ack / (2 ** m_sel[i])) % 2) == 1) begin
          m_active[i] = 0; m_en[i] = 0; m_busy[i] = 0; m_done[i] = 1;
        end else if (m_age[i] == TMO - 1) begin
          m_active[i] = 0; m_en[i] = 0; m_busy[i] = 0; m_done[i] = 1; m_err[i] = 1;
        end else begin
          m_age[i]++;
        end
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("en4",   32'(en4),   m_en[0]);
    chk("sel4",  32'(sel4),  m_sel[0]);
    chk("busy4", 32'(busy4), m_busy[0]);
    chk("done4", 32'(done4), m_done[0]);
    chk("err4",  32'(err4),  m_err[0]);
    chk("en3",   32'(en3),   m_en[1]);
    chk("sel3",  32'(sel3),  m_sel[1]);
    chk("busy3", 32'(busy3), m_busy[1]);
    chk("done3", 32'(done3), m_done[1]);
    chk("err3",  32'(err3),  m_err[1]);
    $display("cyc t=%0t rst=%0b req=%0b addr=%08h ack4=%04b ack3=%03b | en4=%04b done4=%0b err4=%0b en3=%03b done3=%0b err3=%0b",
             $time, reset, req, address, ack4, ack3, en4, done4, err4, en3, done3, err3);
  endtask

  initial begin
    int len;
    reset = 1'b1; req = 1'b0; address = '0; ack4 = '0; ack3 = '0;
    cycle(); cycle();
    chk("rst_en4", 32'(en4), 0);
    chk("rst_busy4", 32'(busy4), 0);
    reset = 1'b0;

    // Mapped decode on slave 1, ack three cycles later
    req = 1'b1; address = 32'h4000_0000;
    cycle();
    chk("t1_en", 32'(en4), 32'h2);
    req = 1'b0;
    cycle(); cycle();
    ack4 = 4'b0010; ack3 = 3'b010;
    cycle();
    chk("t1_done", 32'(done4), 1);
    chk("t1_err", 32'(err4), 0);
    ack4 = '0; ack3 = '0;
    cycle(); cycle();

    // Sweep all four regions; the 3-slave instance flags the top one as unmapped
    for (int i = 0; i < 4; i++) begin
      req = 1'b1; address = 32'(i) << 30;
      cycle();
      chk("sweep_en", 32'(en4), 32'(1) << i);
      if (i == 3) begin
        chk("unmap_err3", 32'(err3), 1);
        chk("unmap_en3", 32'(en3), 0);
      end
      req = 1'b0; ack4 = 4'(1 << i); ack3 = 3'(1 << i);
      cycle();
      chk("sweep_done", 32'(done4), 1);
      ack4 = '0; ack3 = '0;
      cycle();
    end

    // Watchdog expiry on slave 2
    req = 1'b1; address = 32'h8000_0000;
    cycle();
    req = 1'b0;
    len = 0;
    for (int k = 0; k < 40; k++) begin
      if (en4 == 4'b0100) len++;
      if (done4) break;
      cycle();
    end
    chk("tmo_len", 32'(len), TMO);
    chk("tmo_err", 32'(err4), 1);

    // Ack in the final watchdog cycle wins (accepted during the done cycle)
    req = 1'b1; address = 32'h8000_0000;
    cycle();
    req = 1'b0;
    repeat (TMO - 1) cycle();
    ack4 = 4'b0100; ack3 = 3'b100;
    cycle();
    chk("ackwin_done", 32'(done4), 1);
    chk("ackwin_err", 32'(err4), 0);
    ack4 = '0; ack3 = '0;
    cycle();

    // Wrong-slave acks and changing inputs while active
    req = 1'b1; address = 32'h0;
    cycle();
    ack4 = 4'b1110; ack3 = 3'b110; address = 32'h4000_0000;
    repeat (5) begin
      cycle();
      chk("hold_en", 32'(en4), 32'h1);
    end
    ack4 = 4'b0001; ack3 = 3'b001; req = 1'b0;
    cycle();
    chk("hold_done", 32'(done4), 1);
    ack4 = '0; ack3 = '0;
    cycle();

    // Reset while active on slave 3
    req = 1'b1; address = 32'hC000_0000;
    cycle();
    req = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    chk("rst_mid_en", 32'(en4), 0);
    chk("rst_mid_done", 32'(done4), 0);
    reset = 1'b0;

    // Back-to-back with req held high
    req = 1'b1; address = 32'h4000_0000;
    cycle(); cycle();
    ack4 = 4'b0010; ack3 = 3'b010;
    cycle();
    chk("b2b_gap_en", 32'(en4), 0);
    ack4 = '0; ack3 = '0;
    cycle();
    chk("b2b_en", 32'(en4), 32'h2);
    req = 1'b0; ack4 = 4'b0010; ack3 = 3'b010;
    cycle();
    ack4 = '0; ack3 = '0;

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      reset   = ($urandom_range(0, 79) == 0);
      req     = $urandom_range(0, 1) == 1;
      address = $urandom;
      ack4    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      ack3    = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b0;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
